ltc2308_responder: RTL and testbench

LTC2308_RESPONDER -- requirements
Module: ltc2308_responder

---
 rtl/ltc2308_responder.sv | 163 ++++++++++++++++
 tb/tb_ltc2308_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2308_responder.sv
// rtl/ltc2308_responder.sv - LTC2308 ADC serial responder; optional violation flag via LTC2308_RESPONDER_VIOLATION_EN
module ltc2308_responder #(
    parameter int CONV_CYCLES = 80,
    parameter int RES_BITS    = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                CONVST,
    input  logic                SCK,
    input  logic                SDI,
    output logic                SDO,
    input  logic [RES_BITS-1:0] sample_data,
    output logic [5:0]          cfg_word,
    output logic                cfg_valid,
    output logic                busy,
    output logic                err
);

    localparam int CNT_W = $clog2(CONV_CYCLES + 1);
    localparam int BIT_W = $clog2(RES_BITS + 1);

    typedef enum logic [1:0] {IDLE, CONVERT, READY, SHIFT} state_t;

    state_t              state, state_n;
    logic [2:0]          cv_sync, sck_sync;
    logic [1:0]          sdi_sync;
    logic [CNT_W-1:0]    conv_cnt, conv_cnt_n;
    logic [RES_BITS-1:0] result, result_n;
    logic [RES_BITS-1:0] shreg, shreg_n;
    logic [BIT_W-1:0]    fall_cnt, fall_cnt_n;
    logic [2:0]          cfg_cnt, cfg_cnt_n;
    logic [4:0]          cfg_shift, cfg_shift_n;
    logic [5:0]          cfg_word_n;
    logic                cfg_valid_n;
    logic                sdo_n;
    logic                cv_rise, sck_rise, sck_fall, sdi_bit;

    // Two-flop synchronizers plus one edge-detect stage for the master's pins
    always_ff @(posedge clock) begin
        if (reset) begin
            cv_sync  <= '0;
            sck_sync <= '0;
            sdi_sync <= '0;
        end else begin
            cv_sync  <= {cv_sync[1:0], CONVST};
            sck_sync <= {sck_sync[1:0], SCK};
            sdi_sync <= {sdi_sync[0], SDI};
        end
    end

    assign cv_rise  = cv_sync[1] & ~cv_sync[2];
    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] & sck_sync[2];
    assign sdi_bit  = sdi_sync[1];
    assign busy     = (state == CONVERT);

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            conv_cnt  <= '0;
            result    <= '0;
            shreg     <= '0;
            fall_cnt  <= '0;
            cfg_cnt   <= '0;
            cfg_shift <= '0;
            cfg_word  <= '0;
            cfg_valid <= 1'b0;
            SDO       <= 1'b0;
        end else begin
            state     <= state_n;
            conv_cnt  <= conv_cnt_n;
            result    <= result_n;
            shreg     <= shreg_n;
            fall_cnt  <= fall_cnt_n;
            cfg_cnt   <= cfg_cnt_n;
            cfg_shift <= cfg_shift_n;
            cfg_word  <= cfg_word_n;
            cfg_valid <= cfg_valid_n;
            SDO       <= sdo_n;
        end
    end

    // Next-state logic; SDO holds the bit on the wire, shreg holds the bits still to come
    always_comb begin
        state_n     = state;
        conv_cnt_n  = conv_cnt;
        result_n    = result;
        shreg_n     = shreg;
        fall_cnt_n  = fall_cnt;
        cfg_cnt_n   = cfg_cnt;
        cfg_shift_n = cfg_shift;
        cfg_word_n  = cfg_word;
        cfg_valid_n = 1'b0;
        sdo_n       = SDO;

        case (state)
            IDLE: begin
                sdo_n = 1'b0;
            end
            CONVERT: begin
                sdo_n = 1'b0;
                if (conv_cnt == '0) begin
                    sdo_n   = result[RES_BITS-1];
                    shreg_n = {result[RES_BITS-2:0], 1'b0};
                    state_n = READY;
                end else begin
                    conv_cnt_n = conv_cnt - CNT_W'(1);
                end
            end
            READY, SHIFT: begin
                if (sck_rise) begin
                    state_n = SHIFT;
                    if (cfg_cnt < 3'd6) begin
                        cfg_shift_n = {cfg_shift[3:0], sdi_bit};
                        cfg_cnt_n   = cfg_cnt + 3'd1;
                        if (cfg_cnt == 3'd5) begin
                            cfg_word_n  = {cfg_shift, sdi_bit};
                            cfg_valid_n = 1'b1;
                        end
                    end
                end else if (sck_fall && state == SHIFT) begin
                    if (fall_cnt == BIT_W'(RES_BITS - 1)) begin
                        sdo_n   = 1'b0;
                        state_n = IDLE;
                    end else begin
                        sdo_n      = shreg[RES_BITS-1];
                        shreg_n    = {shreg[RES_BITS-2:0], 1'b0};
                        fall_cnt_n = fall_cnt + BIT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A new conversion start overrides everything, aborting any frame in flight
        if (cv_rise) begin
            result_n    = sample_data;
            conv_cnt_n  = CNT_W'(CONV_CYCLES - 1);
            fall_cnt_n  = '0;
            cfg_cnt_n   = '0;
            cfg_shift_n = '0;
            cfg_word_n  = cfg_word;
            cfg_valid_n = 1'b0;
            sdo_n       = 1'b0;
            state_n     = CONVERT;
        end
    end

`ifdef LTC2308_RESPONDER_VIOLATION_EN
    // Sticky flag: the master must leave SCK and CONVST alone while converting
    always_ff @(posedge clock) begin
        if (reset) begin
            err <= 1'b0;
        end else if (state == CONVERT && (sck_rise || sck_fall || cv_rise)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ltc2308_responder.sv
// tb/tb_ltc2308_responder.sv - self-checking bench for ltc2308_responder
module tb_ltc2308_responder;

    localparam int CONV = 80;
    localparam int RES  = 12;
`ifdef LTC2308_RESPONDER_VIOLATION_EN
    localparam logic VIOL = 1'b1;
`else
    localparam logic VIOL = 1'b0;
`endif

    localparam int M_IDLE = 0, M_CONV = 1, M_READY = 2, M_SHIFT = 3;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            CONVST = 1'b0, SCK = 1'b0, SDI = 1'b0;
    logic [RES-1:0]  sample_data = '0;
    logic            SDO, cfg_valid, busy, err;
    logic [5:0]      cfg_word;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    ltc2308_responder #(.CONV_CYCLES(CONV), .RES_BITS(RES)) dut (
        .clock(clock), .reset(reset), .CONVST(CONVST), .SCK(SCK), .SDI(SDI),
        .SDO(SDO), .sample_data(sample_data), .cfg_word(cfg_word),
        .cfg_valid(cfg_valid), .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pin events take effect two samples after they are seen
    logic [2:0] hist[$];
    int         m_mode = M_IDLE;
    int         m_rem = 0;
    logic       m_bits[$];
    int         m_cfg_n = 0;
    logic [5:0] m_acc = '0, m_word = '0;
    logic       m_valid = 1'b0, m_err = 1'b0, m_started = 1'b0;
    logic [RES-1:0] m_result = '0;

    always @(posedge clock) begin
        logic [2:0] o, n;
        if (reset) begin
            hist = '{3'b000, 3'b000, 3'b000, 3'b000};
            m_mode = M_IDLE; m_rem = 0; m_bits.delete(); m_cfg_n = 0;
            m_acc = '0; m_word = '0; m_valid = 1'b0; m_err = 1'b0; m_started = 1'b1;
        end else if (m_started) begin
            hist.push_back({CONVST, SCK, SDI});
            void'(hist.pop_front());
            o = hist[0];
            n = hist[1];
            m_valid = 1'b0;
            if (!o[2] && n[2]) begin
                if (m_mode == M_CONV && VIOL) m_err = 1'b1;
                m_result = sample_data;
                m_mode = M_CONV;
                m_rem = CONV;
                m_bits.delete();
                m_cfg_n = 0;
            end else if (m_mode == M_CONV) begin
                if (o[1] != n[1] && VIOL) m_err = 1'b1;
                m_rem--;
                if (m_rem == 0) begin
                    m_mode = M_READY;
                    for (int i = RES - 1; i >= 0; i--) m_bits.push_back(m_result[i]);
                end
            end else if (m_mode == M_READY || m_mode == M_SHIFT) begin
                if (!o[1] && n[1]) begin
                    m_mode = M_SHIFT;
                    if (m_cfg_n < 6) begin
                        m_acc = {m_acc[4:0], n[0]};
                        m_cfg_n++;
                        if (m_cfg_n == 6) begin
                            m_word = m_acc;
                            m_valid = 1'b1;
                        end
                    end
                end else if (o[1] && !n[1] && m_mode == M_SHIFT) begin
                    void'(m_bits.pop_front());
                    if (m_bits.size() == 0) m_mode = M_IDLE;
                end
            end
        end
    end

    // Compare process: every cycle after the first reset
    always @(negedge clock) begin
        logic exp_sdo;
        if (m_started) begin
            exp_sdo = ((m_mode == M_READY || m_mode == M_SHIFT) && m_bits.size() > 0) ? m_bits[0] : 1'b0;
            chk("model_sdo", SDO, exp_sdo);
            chk("model_busy", busy, m_mode == M_CONV);
            chk("model_cfg_valid", cfg_valid, m_valid);
            chk("model_cfg_word", cfg_word, m_word);
            chk("model_err", err, m_err);
            if (cfg_valid === 1'b1) pulses++;
        end
    end

    task automatic start_conv(input logic [RES-1:0] d);
        @(negedge clock);
        sample_data = d;
        CONVST = 1'b1;
        repeat (4) @(negedge clock);
        CONVST = 1'b0;
    endtask

    task automatic wait_not_busy();
        int k = 0;
        while (busy === 1'b1 && k < 300) begin
            @(negedge clock);
            k++;
        end
        chk("wait_busy_timeout", busy, 1'b0);
        repeat (2) @(negedge clock);
    endtask

    task automatic frame(input int n, input logic [5:0] cfg, output logic [RES-1:0] word);
        word = '0;
        for (int i = 0; i < n; i++) begin
            SDI = (i < 6) ? cfg[5-i] : 1'b0;
            repeat (4) @(negedge clock);
            word = {word[RES-2:0], SDO};
            SCK = 1'b1;
            repeat (4) @(negedge clock);
            SCK = 1'b0;
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [RES-1:0] w;
        int lat, len, pc;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("reset_sdo", SDO, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_cfg_word", cfg_word, 6'b000000);
        chk("reset_cfg_valid", cfg_valid, 1'b0);
        chk("reset_err", err, 1'b0);

        // Basic conversion and frame; busy latency and width
        @(negedge clock);
        sample_data = 12'hA5C;
        CONVST = 1'b1;
        lat = 0;
        while (busy !== 1'b1 && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        CONVST = 1'b0;
        chk("busy_latency", lat, 3);
        len = 0;
        while (busy === 1'b1 && len < 200) begin
            len++;
            @(negedge clock);
        end
        chk("busy_width", len, CONV);
        repeat (2) @(negedge clock);
        frame(12, 6'b100010, w);
        chk("frame_a5c_word", w, 12'hA5C);
        chk("frame_a5c_cfg_word", cfg_word, 6'b100010);
        chk("frame_a5c_pulses", pulses, 1);

        // Short frame aborted by a new conversion
        start_conv(12'h3C3);
        wait_not_busy();
        frame(4, 6'b111111, w);
        start_conv(12'h0F0);
        chk("abort_busy", busy, 1'b1);
        chk("abort_sdo", SDO, 1'b0);
        chk("abort_cfg_word", cfg_word, 6'b100010);
        chk("abort_pulses", pulses, 1);
        wait_not_busy();

        // Back-to-back frames
        start_conv(12'hFFF);
        wait_not_busy();
        frame(12, 6'b000000, w);
        chk("frame_fff_word", w, 12'hFFF);
        chk("frame_fff_sdo_end", SDO, 1'b0);
        start_conv(12'h001);
        wait_not_busy();
        frame(12, 6'b010101, w);
        chk("frame_001_word", w, 12'h001);
        chk("frame_001_sdo_end", SDO, 1'b0);
        chk("frame_001_cfg_word", cfg_word, 6'b010101);
        frame(3, 6'b111111, w);
        chk("idle_sck_word", w, 12'h000);

        // Reset after the 7th SCK edge
        start_conv(12'h7E1);
        wait_not_busy();
        pc = pulses;
        frame(3, 6'b111111, w);
        SDI = 1'b1;
        repeat (4) @(negedge clock);
        SCK = 1'b1;
        repeat (4) @(negedge clock);
        pulse_reset();
        SCK = 1'b0;
        chk("midframe_reset_sdo", SDO, 1'b0);
        chk("midframe_reset_busy", busy, 1'b0);
        chk("midframe_reset_cfg_word", cfg_word, 6'b000000);
        repeat (8) @(negedge clock);
        chk("midframe_reset_pulses", pulses, pc);

        // Protocol violations during conversion
        start_conv(12'h123);
        repeat (10) @(negedge clock);
        SCK = 1'b1;
        repeat (4) @(negedge clock);
        SCK = 1'b0;
        repeat (4) @(negedge clock);
        chk("viol_sck_err", err, VIOL);
        wait_not_busy();
        chk("viol_sck_err_sticky", err, VIOL);
        pulse_reset();
        chk("viol_err_cleared", err, 1'b0);
        start_conv(12'h456);
        repeat (10) @(negedge clock);
        start_conv(12'h456);
        chk("viol_convst_err", err, VIOL);
        wait_not_busy();
        pulse_reset();
        chk("viol_err_cleared2", err, 1'b0);

        repeat (5) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
